multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle MIPS datapath.
- Sequences the architectural and temporary registers (PC, IR, MDR, A/B, ALUOut) by generating their write enables and the mux and ALU selects each cycle.
- Handshakes with the single shared instruction/data memory port.
- Counts retired instructions for debug.

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation, flags unsupported functs.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  // Funct lookup; unsupported codes fall back to add and raise illegal.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath with shared memory port.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  localparam int unsigned WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e            state;
  state_e            state_next;
  logic [CNT_W-1:0]  retired_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              retire;
  logic              mem_state;
  logic              timeout_hit;
  logic              mem_ack;
  logic [2:0]        dec_alu_ctrl;
  logic              dec_illegal;

  alu_decoder u_alu_decoder (
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .illegal  (dec_illegal)
  );

  assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout_hit = (WAIT_MAX != 0) && mem_state && (wait_cnt == WAIT_W'(WAIT_MAX));
  // A completion only counts while the request is actually presented.
  assign mem_ack     = mem_state && mem_ready && !timeout_hit;

  assign retired   = rst ? '0 : retired_q;
  assign state_dbg = rst ? 4'd0 : state;

  // Wait counter: consecutive unanswered request cycles, cleared otherwise.
  always_comb begin
    wait_next = '0;
    if ((WAIT_MAX != 0) && mem_state && !mem_ready && !timeout_hit)
      wait_next = wait_cnt + WAIT_W'(1);
  end

  // State, retired count and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      retired_q <= '0;
      wait_cnt  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and per-state control decode; everything is forced low in reset.
  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_ctrl    = 3'b000;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = !timeout_hit;
          alu_src_b = SRCB_FOUR;
          alu_ctrl  = ALU_ADD;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ack;
          pc_en     = mem_ack;
          if (timeout_hit) begin
            mem_timeout = 1'b1;
            state_next  = S_FETCH;
          end else if (mem_ack) begin
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_ctrl  = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE:     state_next = S_EXEC;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_J:         state_next = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_ctrl   = ALU_ADD;
          state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req   = !timeout_hit;
          iord      = 1'b1;
          mdr_write = mem_ack;
          if (timeout_hit) begin
            mem_timeout = 1'b1;
            state_next  = S_FETCH;
          end else if (mem_ack) begin
            state_next = S_MEMWB;
          end
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = !timeout_hit;
          mem_we  = !timeout_hit;
          iord    = 1'b1;
          if (timeout_hit) begin
            mem_timeout = 1'b1;
            state_next  = S_FETCH;
          end else if (mem_ack) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_ctrl  = dec_alu_ctrl;
          if (dec_illegal) begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_ALUWB;
          end
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_ctrl   = ALU_SUB;
          pc_src     = PCSRC_ALUOUT;
          pc_en      = zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_ctrl   = ALU_ADD;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_en      = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        mdr_write;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic        illegal_op;
  logic        mem_timeout;
  logic [31:0] retired;
  logic [3:0]  state_dbg;
  logic [23:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl #(.CNT_W(32), .WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .mdr_write   (mdr_write),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl    (alu_ctrl),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .retired     (retired),
    .state_dbg   (state_dbg)
  );

  assign outs = {mem_req, mem_we, iord, ir_write, mdr_write, pc_en, pc_src,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                 alu_ctrl, illegal_op, mem_timeout, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land 2 time units after the edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outs", 64'(outs), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_state", 64'(state_dbg), 64'd0);

    // LW, zero-wait memory: 5 cycles
    check("lw_fetch", 64'({mem_req, iord, ir_write, pc_en, alu_src_a, alu_src_b, alu_ctrl, pc_src}),
          64'(13'b1_0_1_1_0_01_010_00));
    nxt();
    check("lw_decode_state", 64'(state_dbg), 64'd1);
    check("lw_decode_alu", 64'({alu_src_a, alu_src_b, alu_ctrl}), 64'(6'b0_11_010));
    nxt();
    check("lw_memadr_state", 64'(state_dbg), 64'd2);
    check("lw_memadr_alu", 64'({mem_req, alu_src_a, alu_src_b, alu_ctrl}), 64'(7'b0_1_10_010));
    nxt();
    check("lw_memrd_state", 64'(state_dbg), 64'd3);
    check("lw_memrd_ctl", 64'({mem_req, mem_we, iord, mdr_write}), 64'(4'b1011));
    nxt();
    check("lw_memwb_state", 64'(state_dbg), 64'd4);
    check("lw_memwb_ctl", 64'({reg_write, reg_dst, mem_to_reg}), 64'(3'b101));
    check("lw_memwb_retired", 64'(retired), 64'd0);
    nxt();
    check("lw_done_state", 64'(state_dbg), 64'd0);
    check("lw_done_retired", 64'(retired), 64'd1);

    // SW with 3 wait cycles in MEMWR
    opcode = 6'b101011;
    nxt(); nxt();
    check("sw_memadr_state", 64'(state_dbg), 64'd2);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      check("sw_wait_state", 64'(state_dbg), 64'd5);
      check("sw_wait_ctl", 64'({mem_req, mem_we, iord, reg_write}), 64'(4'b1110));
      check("sw_wait_retired", 64'(retired), 64'd1);
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    check("sw_ack_ctl", 64'({mem_req, mem_we, iord}), 64'(3'b111));
    nxt();
    check("sw_done_state", 64'(state_dbg), 64'd0);
    check("sw_done_retired", 64'(retired), 64'd2);

    // BEQ taken, then not taken
    opcode = 6'b000100; zero = 1'b1;
    nxt(); nxt();
    #1;
    check("beq_t_state", 64'(state_dbg), 64'd8);
    check("beq_t_ctl", 64'({pc_en, pc_src, alu_ctrl, alu_src_a, alu_src_b}), 64'(9'b1_01_110_1_00));
    nxt();
    check("beq_t_done", 64'({state_dbg, retired[3:0]}), 64'(8'h03));
    zero = 1'b0;
    nxt(); nxt();
    #1;
    check("beq_nt_ctl", 64'({pc_en, pc_src, alu_ctrl, alu_src_a, alu_src_b}), 64'(9'b0_01_110_1_00));
    nxt();
    check("beq_nt_done", 64'({state_dbg, retired[3:0]}), 64'(8'h04));

    // R-type slt
    opcode = 6'b000000; funct = 6'b101010;
    nxt(); nxt();
    check("slt_exec_state", 64'(state_dbg), 64'd6);
    check("slt_exec_ctl", 64'({alu_ctrl, illegal_op, alu_src_a, alu_src_b}), 64'(7'b111_0_1_00));
    nxt();
    check("slt_aluwb_ctl", 64'({state_dbg, reg_write, reg_dst, mem_to_reg}), 64'(7'b0111_110));
    nxt();
    check("slt_done", 64'({state_dbg, retired[3:0]}), 64'(8'h05));

    // R-type with unsupported funct
    funct = 6'b000011;
    nxt(); nxt();
    check("badfn_exec", 64'({state_dbg, illegal_op, reg_write}), 64'(6'b0110_1_0));
    nxt();
    check("badfn_done", 64'({state_dbg, illegal_op, retired[3:0]}), 64'(9'b0000_0_0101));

    // Unsupported opcode
    opcode = 6'b111111;
    nxt();
    check("badop_decode", 64'({state_dbg, illegal_op}), 64'(5'b0001_1));
    nxt();
    check("badop_done", 64'({state_dbg, retired[3:0]}), 64'(8'h05));

    // J and ADDI
    opcode = 6'b000010;
    nxt(); nxt();
    check("j_ctl", 64'({state_dbg, pc_en, pc_src}), 64'(7'b1011_1_10));
    nxt();
    check("j_done", 64'({state_dbg, retired[3:0]}), 64'(8'h06));
    opcode = 6'b001000;
    nxt(); nxt();
    check("addi_ex", 64'({state_dbg, alu_src_a, alu_src_b, alu_ctrl}), 64'(10'b1001_1_10_010));
    nxt();
    check("addi_wb", 64'({state_dbg, reg_write, reg_dst, mem_to_reg}), 64'(7'b1010_100));
    nxt();
    check("addi_done", 64'({state_dbg, retired[3:0]}), 64'(8'h07));

    // Reset during MEMRD
    opcode = 6'b100011;
    nxt(); nxt(); nxt();
    mem_ready = 1'b0;
    #1;
    check("rstmid_memrd", 64'({state_dbg, mem_req}), 64'(5'b0011_1));
    rst = 1'b1;
    #1;
    check("rstmid_outs", 64'(outs), 64'd0);
    check("rstmid_retired", 64'(retired), 64'd0);
    nxt();
    check("rstmid_outs_edge", 64'(outs), 64'd0);
    rst = 1'b0;
    #1;
    check("rstmid_after", 64'({state_dbg, retired[3:0]}), 64'(8'h00));

    // FETCH timeout after 15 unanswered cycles
    for (int i = 0; i < 15; i++) begin
      check("to_wait_req", 64'({mem_req, mem_timeout, state_dbg}), 64'(6'b1_0_0000));
      nxt();
      #1;
    end
    mem_ready = 1'b1;
    #1;
    check("to_pulse", 64'({mem_timeout, mem_req, ir_write, pc_en, state_dbg}), 64'(8'b1_0_0_0_0000));
    nxt();
    check("to_retry", 64'({mem_timeout, mem_req, ir_write, state_dbg}), 64'(7'b0_1_1_0000));
    nxt();
    check("to_retry_decode", 64'({state_dbg, retired[3:0]}), 64'(8'h10));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
